// File: rtl/arm_inst_encoder.sv
// Field-level ARM instruction assembler and loader: packs one descriptor per
// handshake into a 32-bit word and writes it to sequential instruction-memory addresses.
module arm_inst_encoder #(
    parameter int unsigned DEPTH_LOG2 = 8,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_class,
    input  logic [3:0]            req_cond,
    input  logic [3:0]            req_aluop,
    input  logic                  req_s,
    input  logic                  req_imm,
    input  logic                  req_up,
    input  logic                  req_link,
    input  logic [3:0]            req_rn,
    input  logic [3:0]            req_rd,
    input  logic [23:0]           req_operand,
    output logic                  wr_req,
    output logic [31:0]           wr_addr,
    output logic [31:0]           wr_data,
    input  logic                  wr_ack,
    input  logic                  flush,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  err
);

    localparam int unsigned CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] CAP = {1'b1, {DEPTH_LOG2{1'b0}}};

    localparam logic [1:0] CLS_DP  = 2'b00;
    localparam logic [1:0] CLS_MEM = 2'b01;
    localparam logic [1:0] CLS_BR  = 2'b10;
    localparam logic [1:0] CLS_ILL = 2'b11;

    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_MOV = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_WRITE = 2'b01,
        S_FULL  = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [31:0]     addr_q,  addr_d;
    logic [31:0]     data_q,  data_d;
    logic            err_q,   err_d;
    logic            full_q,  full_d;
    logic [31:0]     enc_c;
    logic            ready_c;

    // Instruction word packing; CMP always sets flags, MOV has no first operand.
    always_comb begin
        enc_c        = '0;
        enc_c[31:28] = req_cond;
        enc_c[27:26] = req_class;
        case (req_class)
            CLS_DP: begin
                enc_c[25]    = req_imm;
                enc_c[24:21] = req_aluop;
                enc_c[20]    = req_s | (req_aluop == OP_CMP);
                enc_c[19:16] = (req_aluop == OP_MOV) ? 4'h0 : req_rn;
                enc_c[15:12] = req_rd;
                enc_c[11:0]  = req_operand[11:0];
            end
            CLS_MEM: begin
                enc_c[25]    = ~req_imm;
                enc_c[24]    = 1'b1;
                enc_c[23]    = req_up;
                enc_c[22:21] = 2'b00;
                enc_c[20]    = req_s;
                enc_c[19:16] = req_rn;
                enc_c[15:12] = req_rd;
                enc_c[11:0]  = req_operand[11:0];
            end
            CLS_BR: begin
                enc_c[25]    = 1'b1;
                enc_c[24]    = req_link;
                enc_c[23:0]  = req_operand;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            count_q <= '0;
            addr_q  <= BASE_ADDR;
            data_q  <= '0;
            err_q   <= 1'b0;
            full_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            err_q   <= err_d;
            full_q  <= full_d;
        end
    end

    // Next-state logic; flush overrides everything, including a same-cycle ack.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        addr_d  = addr_q;
        data_d  = data_q;
        err_d   = err_q;
        full_d  = full_q;
        ready_c = 1'b0;

        case (state_q)
            S_IDLE: begin
                ready_c = ~flush;
                if (req_valid && !flush) begin
                    if (req_class == CLS_ILL) begin
                        err_d = 1'b1;
                    end else begin
                        data_d  = enc_c;
                        state_d = S_WRITE;
                    end
                end
            end
            S_WRITE: begin
                if (wr_ack) begin
                    count_d = count_q + CW'(1);
                    addr_d  = addr_q + 32'd4;
                    if (count_q + CW'(1) == CAP) begin
                        state_d = S_FULL;
                        full_d  = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_FULL: ;
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
            count_d = '0;
            addr_d  = BASE_ADDR;
            err_d   = 1'b0;
            full_d  = 1'b0;
        end
    end

    assign req_ready = ready_c & reset_n;
    assign wr_req    = (state_q == S_WRITE);
    assign wr_addr   = addr_q;
    assign wr_data   = data_q;
    assign count     = count_q;
    assign full      = full_q;
    assign err       = err_q;

endmodule

// File: tb/tb_arm_inst_encoder.sv
// Self-checking bench for arm_inst_encoder: expected writes are queued at
// acceptance and compared when the DUT presents them with wr_ack.
module tb_arm_inst_encoder;

    localparam int unsigned DL2  = 2;
    localparam int unsigned CW   = DL2 + 1;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic          clk;
    logic          reset_n;
    logic          req_valid;
    logic          req_ready;
    logic [1:0]    req_class;
    logic [3:0]    req_cond;
    logic [3:0]    req_aluop;
    logic          req_s;
    logic          req_imm;
    logic          req_up;
    logic          req_link;
    logic [3:0]    req_rn;
    logic [3:0]    req_rd;
    logic [23:0]   req_operand;
    logic          wr_req;
    logic [31:0]   wr_addr;
    logic [31:0]   wr_data;
    logic          wr_ack;
    logic          flush;
    logic [CW-1:0] count;
    logic          full;
    logic          err;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   errors = 0;
    int   checks = 0;
    int   model_count = 0;

    arm_inst_encoder #(.DEPTH_LOG2(DL2), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_class(req_class), .req_cond(req_cond), .req_aluop(req_aluop),
        .req_s(req_s), .req_imm(req_imm), .req_up(req_up), .req_link(req_link),
        .req_rn(req_rn), .req_rd(req_rd), .req_operand(req_operand),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .flush(flush), .count(count), .full(full), .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_desc(input logic [1:0] cls, input logic [3:0] cond,
                              input logic [3:0] aluop, input logic s, input logic imm,
                              input logic up, input logic link, input logic [3:0] rn,
                              input logic [3:0] rd, input logic [23:0] op);
        req_class   = cls;
        req_cond    = cond;
        req_aluop   = aluop;
        req_s       = s;
        req_imm     = imm;
        req_up      = up;
        req_link    = link;
        req_rn      = rn;
        req_rd      = rd;
        req_operand = op;
    endtask

    // Accept the currently driven descriptor and ack it after ack_delay stall cycles.
    task automatic send(input string name, input logic [31:0] exp_data, input int ack_delay);
        int   n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        n = 0;
        while (req_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s_ready: req_ready=%b required 1 (timeout)", name, req_ready);
            req_valid = 1'b0;
            return;
        end
        sb_q.push_back('{addr: BASE + 32'(4 * model_count), data: exp_data});
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int k = 0; k < ack_delay; k++) begin
            @(negedge clk);
            checks++;
            if (wr_req !== 1'b1 || req_ready !== 1'b0 ||
                wr_addr !== sb_q[0].addr || wr_data !== sb_q[0].data) begin
                errors++;
                $display("FAIL %s_hold%0d: wr_req=%b req_ready=%b addr=%h data=%h required 1 0 %h %h",
                         name, k, wr_req, req_ready, wr_addr, wr_data, sb_q[0].addr, sb_q[0].data);
            end
        end
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (wr_req !== 1'b1 || wr_addr !== e.addr || wr_data !== e.data) begin
            errors++;
            $display("FAIL %s_write: wr_req=%b addr=%h data=%h required 1 %h %h",
                     name, wr_req, wr_addr, wr_data, e.addr, e.data);
        end
        wr_ack = 1'b1;
        @(posedge clk);
        #1 wr_ack = 1'b0;
        model_count++;
        checks++;
        if (count !== CW'(model_count)) begin
            errors++;
            $display("FAIL %s_count: count=%0d required %0d", name, count, model_count);
        end
    endtask

    task automatic pulse_flush();
        @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        req_valid = 1'b0;
        model_count = 0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req_valid = 1'b0;
        wr_ack = 1'b0;
        flush = 1'b0;
        drive_desc(2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'h0);
        repeat (2) @(negedge clk);
        checks++;
        if (req_ready !== 1'b0 || wr_req !== 1'b0 || wr_addr !== BASE || wr_data !== 32'h0 ||
            count !== '0 || full !== 1'b0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_vals: rdy=%b req=%b addr=%h data=%h cnt=%0d full=%b err=%b required 0 0 %h 0 0 0 0",
                     req_ready, wr_req, wr_addr, wr_data, count, full, err, BASE);
        end
        reset_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: req_ready=%b required 1", req_ready);
        end
    endtask

    task automatic test_dp_mem();
        drive_desc(2'b00, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd1, 24'h000005);
        send("add", 32'hE282_1005, 0);
        drive_desc(2'b01, 4'hE, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 24'h000008);
        send("ldr", 32'hE591_0008, 0);
        drive_desc(2'b01, 4'hE, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd1, 4'd0, 24'h000004);
        send("str", 32'hE501_0004, 0);
        drive_desc(2'b00, 4'hE, 4'b1010, 1'b0, 1'b1, 1'b0, 1'b0, 4'd3, 4'd0, 24'h000000);
        send("cmp", 32'hE353_0000, 0);
        checks++;
        if (full !== 1'b1 || count !== CW'(4)) begin
            errors++;
            $display("FAIL full_set: full=%b count=%0d required 1 4", full, count);
        end
    endtask

    task automatic test_full_stall();
        drive_desc(2'b00, 4'hE, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 4'd4, 24'h0000FF);
        @(negedge clk);
        req_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (req_ready !== 1'b0 || wr_req !== 1'b0 || count !== CW'(4)) begin
                errors++;
                $display("FAIL stall%0d: rdy=%b req=%b count=%0d required 0 0 4", k, req_ready, wr_req, count);
            end
        end
    endtask

    task automatic test_flush();
        pulse_flush();
        @(negedge clk);
        checks++;
        if (count !== '0 || wr_addr !== BASE || full !== 1'b0 || wr_req !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: count=%0d addr=%h full=%b req=%b required 0 %h 0 0",
                     count, wr_addr, full, wr_req, BASE);
        end
    endtask

    task automatic test_branch();
        drive_desc(2'b10, 4'h1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'hFFFFFD);
        send("bne_delay", 32'h1AFF_FFFD, 3);
        drive_desc(2'b10, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 24'h000002);
        send("bl", 32'hEB00_0002, 0);
        drive_desc(2'b00, 4'hE, 4'b1101, 1'b0, 1'b1, 1'b0, 1'b0, 4'd7, 4'd4, 24'h0000FF);
        send("mov", 32'hE3A0_40FF, 1);
    endtask

    task automatic test_illegal();
        drive_desc(2'b11, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h0, 4'h0, 24'h0);
        @(negedge clk);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (err !== 1'b1 || wr_req !== 1'b0 || count !== CW'(model_count)) begin
            errors++;
            $display("FAIL illegal: err=%b req=%b count=%0d required 1 0 %0d", err, wr_req, count, model_count);
        end
    endtask

    task automatic test_flush_ack();
        pulse_flush();
        @(negedge clk);
        checks++;
        if (err !== 1'b0 || count !== '0) begin
            errors++;
            $display("FAIL flush_err: err=%b count=%0d required 0 0", err, count);
        end
        drive_desc(2'b00, 4'hE, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b0, 4'd2, 4'd1, 24'h000005);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        flush = 1'b1;
        wr_ack = 1'b1;
        @(posedge clk);
        #1 flush = 1'b0;
        wr_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (wr_req !== 1'b0 || count !== '0 || wr_addr !== BASE) begin
            errors++;
            $display("FAIL flush_ack: req=%b count=%0d addr=%h required 0 0 %h", wr_req, count, wr_addr, BASE);
        end
        drive_desc(2'b10, 4'hE, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h0, 4'h0, 24'h000002);
        send("after_flush", 32'hEB00_0002, 0);
    endtask

    task automatic test_reset_mid_write();
        drive_desc(2'b01, 4'hE, 4'h0, 1'b1, 1'b1, 1'b1, 1'b0, 4'd1, 4'd0, 24'h000008);
        @(negedge clk);
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        checks++;
        if (wr_req !== 1'b0 || req_ready !== 1'b0 || count !== '0 || wr_addr !== BASE || wr_data !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid: req=%b rdy=%b count=%0d addr=%h data=%h required 0 0 0 %h 0",
                     wr_req, req_ready, count, wr_addr, wr_data, BASE);
        end
        @(negedge clk);
        reset_n = 1'b1;
        model_count = 0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_dp_mem();
        test_full_stall();
        test_flush();
        test_branch();
        test_illegal();
        test_flush_ack();
        test_reset_mid_write();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/arm_inst_encoder.md
# arm_inst_encoder

Field-level ARM instruction assembler and program loader for the single-cycle ARM system. Accepts one instruction descriptor per handshake (class, condition, ALU command, flags, registers, operand), packs it into the 32-bit word the control-unit decoder consumes, and writes it into instruction memory at sequentially increasing word addresses. Used by the boot/test loader path to fill instruction memory before the core is released.

## Interface
Parameters:
- DEPTH_LOG2, 8, log2 of instruction-memory capacity in words
- BASE_ADDR, 32'h0000_0000, byte address of the first written word (word-aligned)

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- req_valid  in  1  descriptor valid
- req_ready  out  1  encoder can accept a descriptor this cycle
- req_class  in  2  00 data-processing, 01 load/store, 10 branch, 11 illegal
- req_cond  in  4  condition field
- req_aluop  in  4  DP command (0100 ADD, 0010 SUB, 1010 CMP, 1101 MOV, others pass through)
- req_s  in  1  DP: S bit; load/store: L bit (1 = LDR)
- req_imm  in  1  1 = immediate operand/offset
- req_up  in  1  load/store U bit
- req_link  in  1  branch L bit (BL)
- req_rn, req_rd  in  4 each  register fields
- req_operand  in  24  DP/mem: [11:0] operand2/offset; branch: [23:0] signed word offset
- wr_req  out  1  memory write request
- wr_addr  out  32  byte address of write
- wr_data  out  32  encoded instruction
- wr_ack  in  1  memory accepted write this cycle
- flush  in  1  synchronous restart
- count  out  DEPTH_LOG2+1  words written since reset/flush
- full  out  1  count == 2**DEPTH_LOG2
- err  out  1  sticky: illegal class received

## Operation
- Encoding, common: word[31:28]=cond, word[27:26]=class.
- DP: [25]=req_imm, [24:21]=aluop, [20]=req_s, forced 1 when aluop=1010; [19:16]=rn, forced 0 when aluop=1101; [15:12]=rd; [11:0]=operand[11:0].
- Load/store: [25]=~req_imm, [24]=1 (P), [23]=req_up, [22:21]=00, [20]=req_s, [19:16]=rn, [15:12]=rd, [11:0]=operand[11:0].
- Branch: [25]=1, [24]=req_link, [23:0]=operand[23:0].
- FSM states IDLE, WRITE, FULL.
  - IDLE: req_ready = !flush. Accept on valid&ready.
    - Class 11: set err. No write, stay IDLE.
    - Otherwise: register the encoded word into wr_data, go to WRITE.
  - WRITE: wr_req=1; wr_addr/wr_data held stable until wr_ack is sampled high.
    - On ack: count+1, wr_addr+4.
    - Next state is FULL if the new count equals 2**DEPTH_LOG2, else IDLE.
  - FULL: req_ready=0; descriptors stall (valid held, not consumed).
- wr_addr = BASE_ADDR + 4*count; 32-bit arithmetic, no wrap (FULL prevents overflow).
- flush, any state: next edge goes to IDLE, count=0, wr_addr=BASE_ADDR, err=0, wr_req=0; any pending write is abandoned.
  - flush with req_valid: the descriptor is not accepted.
  - flush with wr_ack: flush wins and count does not increment.
- Reset mid-write: wr_req drops immediately (asynchronous); no partial state survives.

## Timing
- Reset values: req_ready=0 while reset_n low; wr_req=0, wr_addr=BASE_ADDR, wr_data=0, count=0, full=0, err=0, state IDLE. req_ready=1 in the first cycle after release (if flush low).
- Accept at edge N: wr_req high from cycle N+1. Earliest ack is sampled at edge N+1, so req_ready is high again in cycle N+2. Peak throughput is 1 word per 2 cycles.
- wr_ack is ignored when wr_req=0.
- err is registered and rises the cycle after the illegal accept.
- count and full update on the ack edge.

## Test plan
- Reset release, then ADD R1,R2,#5 (class 00, cond 1110, aluop 0100, s0, imm1, rn2, rd1, op 0x005), ack in the same cycle -> wr_data=E2821005, wr_addr=BASE_ADDR, count=1.
- LDR R0,[R1,#8] (class 01, imm1, up1, s1) -> E5910008 at +4. STR R0,[R1,#-4] (up0, s0) -> E5010004 at +8.
- CMP R3,#0 with req_s=0 -> E3530000 (S forced). BNE offset 24'hFFFFFD -> 1AFFFFFD. BL AL offset 2 -> EB000002.
- wr_ack delayed 3 cycles -> wr_req, wr_addr and wr_data are stable for all 4 cycles; req_ready stays low; exactly one count increment.
- DEPTH_LOG2=2: four writes -> full=1, count=4, 5th descriptor stalls with req_ready=0. Pulse flush -> count=0, wr_addr=BASE_ADDR, next descriptor written at BASE_ADDR.
- Class 11 -> err=1, no wr_req, count unchanged. Flush asserted with wr_ack pending -> write dropped, count stays. reset_n low during WRITE -> wr_req=0 immediately.
